// File: rtl/conduit_arbiter_pkg.sv
// Shared types for the conduit arbiter: FSM states and the operation kind.
package conduit_arbiter_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  typedef enum logic {OP_WR, OP_RD} op_e;

  localparam int unsigned TimerWidth = 16;

endpackage

// File: rtl/conduit_arbiter_if.sv
// Requester and target signal bundle; slave is the arbiter side, master the environment side.
interface conduit_arbiter_if #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 12,
  parameter int unsigned N_REQ   = 2
);
  localparam int unsigned BE_W = D_WIDTH / 8;

  logic [N_REQ-1:0]              req_wr;
  logic [N_REQ-1:0]              req_rd;
  logic [N_REQ-1:0][A_WIDTH-1:0] req_addr;
  logic [N_REQ-1:0][D_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0][BE_W-1:0]    req_be;
  logic [N_REQ-1:0]              req_wr_ack;
  logic [N_REQ-1:0]              req_read_valid;
  logic [N_REQ-1:0]              req_slv_error;
  logic [D_WIDTH-1:0]            req_rdata;

  logic                          tgt_wr;
  logic                          tgt_rd;
  logic [A_WIDTH-1:0]            tgt_addr;
  logic [D_WIDTH-1:0]            tgt_wdata;
  logic [BE_W-1:0]               tgt_be;
  logic                          tgt_wr_ack;
  logic                          tgt_read_valid;
  logic                          tgt_slv_error;
  logic [D_WIDTH-1:0]            tgt_rdata;

  modport slave (
    input  req_wr, req_rd, req_addr, req_wdata, req_be,
    output req_wr_ack, req_read_valid, req_slv_error, req_rdata,
    output tgt_wr, tgt_rd, tgt_addr, tgt_wdata, tgt_be,
    input  tgt_wr_ack, tgt_read_valid, tgt_slv_error, tgt_rdata
  );

  modport master (
    output req_wr, req_rd, req_addr, req_wdata, req_be,
    input  req_wr_ack, req_read_valid, req_slv_error, req_rdata,
    input  tgt_wr, tgt_rd, tgt_addr, tgt_wdata, tgt_be,
    output tgt_wr_ack, tgt_read_valid, tgt_slv_error, tgt_rdata
  );

endinterface

// File: rtl/conduit_arbiter_rr_grant_sel.sv
// Round-robin picker: first pending slot searching upward from last_grant+1, wrapping.
module rr_grant_sel #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!valid && pending[IDX_W'((32'(last_grant) + k) % N_REQ)]) begin
        valid = 1'b1;
        grant = IDX_W'((32'(last_grant) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/conduit_arbiter.sv
// Arbitrates single-cycle read/write pulses from N_REQ requesters onto one shared target,
// one operation in flight at a time, with a response timeout.
module conduit_arbiter
  import conduit_arbiter_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 12,
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             pclk,
  input  logic             presetn,
  conduit_arbiter_if.slave bus,
  output logic             busy
);

  localparam int unsigned BE_W  = D_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam logic [TimerWidth-1:0] TIMEOUT_LAST = TimerWidth'(TIMEOUT - 1);

  logic [N_REQ-1:0]              slot_valid_q;
  op_e                           slot_op_q [N_REQ];
  logic [N_REQ-1:0][A_WIDTH-1:0] slot_addr_q;
  logic [N_REQ-1:0][D_WIDTH-1:0] slot_wdata_q;
  logic [N_REQ-1:0][BE_W-1:0]    slot_be_q;

  state_e                state_q;
  op_e                   op_q;
  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      last_grant_q;
  logic [TimerWidth-1:0] wait_cnt_q;
  logic                  tgt_wr_q;
  logic                  tgt_rd_q;
  logic [A_WIDTH-1:0]    tgt_addr_q;
  logic [D_WIDTH-1:0]    tgt_wdata_q;
  logic [BE_W-1:0]       tgt_be_q;
  logic [N_REQ-1:0]      wr_ack_q;
  logic [N_REQ-1:0]      rd_valid_q;
  logic [N_REQ-1:0]      slv_err_q;
  logic [D_WIDTH-1:0]    rdata_q;

  logic [IDX_W-1:0] sel_grant;
  logic             sel_valid;
  logic [N_REQ-1:0] grant_oh;
  logic             accept_ok;
  logic             timeout_hit;
  logic             resp_fire;

  rr_grant_sel #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_grant_sel (
    .pending    (slot_valid_q),
    .last_grant (last_grant_q),
    .grant      (sel_grant),
    .valid      (sel_valid)
  );

  always_comb begin
    grant_oh    = N_REQ'(1) << grant_q;
    accept_ok   = (op_q == OP_WR) ? bus.tgt_wr_ack : bus.tgt_read_valid;
    timeout_hit = (wait_cnt_q == TIMEOUT_LAST);
    resp_fire   = (state_q == StWait) && (bus.tgt_slv_error || accept_ok || timeout_hit);
  end

  // A slot stays full while in service, so repeat pulses from its owner are dropped.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      slot_valid_q <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      slot_be_q    <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) slot_op_q[i] <= OP_WR;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (resp_fire && grant_oh[i]) begin
          slot_valid_q[i] <= 1'b0;
        end else if (!slot_valid_q[i] && (bus.req_wr[i] || bus.req_rd[i])) begin
          slot_valid_q[i] <= 1'b1;
          slot_op_q[i]    <= bus.req_wr[i] ? OP_WR : OP_RD;
          slot_addr_q[i]  <= bus.req_addr[i];
          slot_wdata_q[i] <= bus.req_wdata[i];
          slot_be_q[i]    <= bus.req_be[i];
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= StIdle;
      op_q         <= OP_WR;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      wait_cnt_q   <= '0;
      tgt_wr_q     <= 1'b0;
      tgt_rd_q     <= 1'b0;
      tgt_addr_q   <= '0;
      tgt_wdata_q  <= '0;
      tgt_be_q     <= '0;
      wr_ack_q     <= '0;
      rd_valid_q   <= '0;
      slv_err_q    <= '0;
      rdata_q      <= '0;
    end else begin
      wr_ack_q   <= '0;
      rd_valid_q <= '0;
      slv_err_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            grant_q      <= sel_grant;
            last_grant_q <= sel_grant;
            op_q         <= slot_op_q[sel_grant];
            tgt_wr_q     <= (slot_op_q[sel_grant] == OP_WR);
            tgt_rd_q     <= (slot_op_q[sel_grant] == OP_RD);
            tgt_addr_q   <= slot_addr_q[sel_grant];
            tgt_wdata_q  <= slot_wdata_q[sel_grant];
            tgt_be_q     <= slot_be_q[sel_grant];
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          tgt_wr_q   <= 1'b0;
          tgt_rd_q   <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // A real response wins over a timeout expiring in the same cycle.
          if (bus.tgt_slv_error) begin
            slv_err_q <= grant_oh;
            state_q   <= StIdle;
          end else if (accept_ok && op_q == OP_WR) begin
            wr_ack_q <= grant_oh;
            state_q  <= StIdle;
          end else if (accept_ok) begin
            rd_valid_q <= grant_oh;
            rdata_q    <= bus.tgt_rdata;
            state_q    <= StIdle;
          end else if (timeout_hit) begin
            slv_err_q <= grant_oh;
            state_q   <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + TimerWidth'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tgt_wr         = tgt_wr_q;
  assign bus.tgt_rd         = tgt_rd_q;
  assign bus.tgt_addr       = tgt_addr_q;
  assign bus.tgt_wdata      = tgt_wdata_q;
  assign bus.tgt_be         = tgt_be_q;
  assign bus.req_wr_ack     = wr_ack_q;
  assign bus.req_read_valid = rd_valid_q;
  assign bus.req_slv_error  = slv_err_q;
  assign bus.req_rdata      = rdata_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_conduit_arbiter.sv
// Directed bench for conduit_arbiter: writes, reads, round-robin, timeout, error and reset abort.
module tb_conduit_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 8;

  logic pclk    = 1'b0;
  logic presetn = 1'b1;
  logic busy;

  int n_assert = 0;
  int n_fail   = 0;

  int mon_tgt_wr = 0;
  int mon_tgt_rd = 0;
  int mon_ack [NR];
  int mon_rv  [NR];
  int mon_err [NR];
  int base_a, base_b, base_c;

  conduit_arbiter_if #(.D_WIDTH(DW), .A_WIDTH(AW), .N_REQ(NR)) bus ();

  conduit_arbiter #(
    .D_WIDTH (DW),
    .A_WIDTH (AW),
    .N_REQ   (NR),
    .TIMEOUT (TO)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 pclk = ~pclk;

  initial for (int i = 0; i < NR; i++) begin
    mon_ack[i] = 0;
    mon_rv[i]  = 0;
    mon_err[i] = 0;
  end

  // Pulse counters sampled on the active edge (pre-update values).
  always @(posedge pclk) begin
    if (presetn) begin
      mon_tgt_wr += int'(bus.tgt_wr);
      mon_tgt_rd += int'(bus.tgt_rd);
      for (int i = 0; i < NR; i++) begin
        mon_ack[i] += int'(bus.req_wr_ack[i]);
        mon_rv[i]  += int'(bus.req_read_valid[i]);
        mon_err[i] += int'(bus.req_slv_error[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {busy, bus.tgt_wr, bus.tgt_rd, bus.req_wr_ack, bus.req_read_valid,
                        bus.req_slv_error, bus.tgt_be, bus.tgt_addr}, 64'h0);
    chk({tag, "_wdata"}, bus.tgt_wdata, 64'h0);
    chk({tag, "_rdata"}, bus.req_rdata, 64'h0);
  endtask

  initial begin
    bus.req_wr         = '0;
    bus.req_rd         = '0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.req_be         = '0;
    bus.tgt_wr_ack     = 1'b0;
    bus.tgt_read_valid = 1'b0;
    bus.tgt_slv_error  = 1'b0;
    bus.tgt_rdata      = '0;

    #2 presetn = 1'b0;
    #1 chk_all_zero("reset");
    cyc(2);
    presetn = 1'b1;
    cyc(1);

    // Single write from requester 1, target acks in the first WAIT cycle.
    base_a = mon_ack[1];
    bus.req_wr[1] = 1'b1; bus.req_addr[1] = 12'h010;
    bus.req_wdata[1] = 32'hA5A5A5A5; bus.req_be[1] = 4'hF;
    cyc(1);
    bus.req_wr = '0;
    chk("wr_latch_idle", busy, 1'b0);
    cyc(1);
    chk("wr_issue_pulse", {busy, bus.tgt_wr, bus.tgt_rd}, 3'b110);
    chk("wr_issue_addr", bus.tgt_addr, 12'h010);
    chk("wr_issue_wdata", bus.tgt_wdata, 32'hA5A5A5A5);
    chk("wr_issue_be", bus.tgt_be, 4'hF);
    cyc(1);
    chk("wr_wait", {bus.tgt_wr, bus.tgt_addr}, {1'b0, 12'h010});
    bus.tgt_wr_ack = 1'b1;
    cyc(1);
    bus.tgt_wr_ack = 1'b0;
    chk("wr_ack_pulse", {busy, bus.req_wr_ack}, 3'b010);
    cyc(1);
    chk("wr_ack_low", bus.req_wr_ack, 2'b00);
    cyc(2);
    chk("wr_ack_once", 64'(mon_ack[1] - base_a), 64'd1);

    // Simultaneous write and read from one requester: write wins.
    base_b = mon_tgt_rd;
    bus.req_wr[1] = 1'b1; bus.req_rd[1] = 1'b1; bus.req_addr[1] = 12'h0AB;
    bus.req_wdata[1] = 32'hDEADBEEF; bus.req_be[1] = 4'h3;
    cyc(1);
    bus.req_wr = '0; bus.req_rd = '0;
    cyc(1);
    chk("wrrd_issue", {bus.tgt_wr, bus.tgt_rd, bus.tgt_be}, {2'b10, 4'h3});
    cyc(1);
    bus.tgt_wr_ack = 1'b1;
    cyc(1);
    bus.tgt_wr_ack = 1'b0;
    chk("wrrd_resp", {bus.req_wr_ack, bus.req_read_valid}, 4'b1000);
    cyc(3);
    chk("wrrd_no_read", 64'(mon_tgt_rd - base_b), 64'd0);

    // Fresh reset, then both requesters read in the same cycle: 0 first.
    presetn = 1'b0;
    cyc(2);
    presetn = 1'b1;
    cyc(1);
    bus.req_rd = 2'b11; bus.req_addr[0] = 12'h020; bus.req_addr[1] = 12'h024;
    cyc(1);
    bus.req_rd = '0;
    cyc(1);
    chk("rr_first", {bus.tgt_rd, bus.tgt_addr}, {1'b1, 12'h020});
    cyc(1);
    bus.tgt_read_valid = 1'b1; bus.tgt_rdata = 32'h11111111;
    cyc(1);
    bus.tgt_read_valid = 1'b0; bus.tgt_rdata = 32'hBAD0BAD0;
    chk("rr_rv0", {busy, bus.req_read_valid}, 3'b001);
    chk("rr_rdata0", bus.req_rdata, 32'h11111111);
    cyc(1);
    chk("rr_second", {bus.tgt_rd, bus.tgt_addr, bus.req_read_valid}, {1'b1, 12'h024, 2'b00});
    chk("rr_rdata_hold", bus.req_rdata, 32'h11111111);
    cyc(1);
    bus.tgt_wr_ack = 1'b1;
    cyc(1);
    bus.tgt_wr_ack = 1'b0;
    chk("rr_unmatched_ignored", {busy, bus.req_read_valid, bus.req_wr_ack}, 5'b10000);
    bus.tgt_read_valid = 1'b1; bus.tgt_rdata = 32'h22222222;
    cyc(1);
    bus.tgt_read_valid = 1'b0; bus.tgt_rdata = '0;
    chk("rr_rv1", {busy, bus.req_read_valid}, 3'b010);
    chk("rr_rdata1", bus.req_rdata, 32'h22222222);
    cyc(1);

    // Silent target: error after TO WAIT cycles.
    bus.req_rd[0] = 1'b1; bus.req_addr[0] = 12'h050;
    cyc(1);
    bus.req_rd = '0;
    cyc(1);
    chk("to_issue", bus.tgt_rd, 1'b1);
    cyc(1);
    for (int k = 0; k < int'(TO); k++) begin
      chk("to_waiting", {busy, bus.req_slv_error}, 3'b100);
      cyc(1);
    end
    chk("to_error", {busy, bus.req_slv_error}, 3'b001);
    chk("to_rdata_kept", bus.req_rdata, 32'h22222222);
    cyc(1);
    chk("to_error_low", bus.req_slv_error, 2'b00);

    // Target error during a write.
    base_a = mon_ack[0];
    base_b = mon_err[0];
    bus.req_wr[0] = 1'b1; bus.req_addr[0] = 12'h060;
    bus.req_wdata[0] = 32'h12345678; bus.req_be[0] = 4'hF;
    cyc(1);
    bus.req_wr = '0;
    cyc(1);
    chk("err_issue", bus.tgt_wr, 1'b1);
    cyc(1);
    bus.tgt_slv_error = 1'b1;
    cyc(1);
    bus.tgt_slv_error = 1'b0;
    chk("err_resp", {bus.req_slv_error, bus.req_wr_ack}, 4'b0100);
    cyc(2);
    chk("err_counts", {32'(mon_ack[0] - base_a), 32'(mon_err[0] - base_b)}, {32'd0, 32'd1});

    // Repeat write while the first is in WAIT must be dropped.
    base_c = mon_tgt_wr;
    bus.req_wr[0] = 1'b1; bus.req_addr[0] = 12'h070; bus.req_wdata[0] = 32'h1;
    cyc(1);
    bus.req_wr = '0;
    cyc(1);
    chk("dup_issue", {bus.tgt_wr, bus.tgt_wdata}, {1'b1, 32'h1});
    cyc(1);
    bus.req_wr[0] = 1'b1; bus.req_addr[0] = 12'h074; bus.req_wdata[0] = 32'h2;
    cyc(1);
    bus.req_wr = '0;
    chk("dup_still_wait", busy, 1'b1);
    cyc(1);
    bus.tgt_wr_ack = 1'b1;
    cyc(1);
    bus.tgt_wr_ack = 1'b0;
    chk("dup_ack", {bus.req_wr_ack, bus.tgt_wdata}, {2'b01, 32'h1});
    cyc(4);
    chk("dup_single_wr", {busy, 32'(mon_tgt_wr - base_c)}, {1'b0, 32'd1});

    // Reset in WAIT: outputs clear at once, no late response.
    bus.req_wr[1] = 1'b1; bus.req_addr[1] = 12'h080;
    bus.req_wdata[1] = 32'hCAFEF00D; bus.req_be[1] = 4'hC;
    cyc(1);
    bus.req_wr = '0;
    cyc(2);
    chk("rst_pre", {busy, bus.tgt_addr}, {1'b1, 12'h080});
    base_a = mon_ack[1];
    base_b = mon_err[1];
    presetn = 1'b0;
    #1 chk_all_zero("rst_wait");
    bus.tgt_wr_ack = 1'b1;
    cyc(2);
    presetn = 1'b1;
    cyc(1);
    bus.tgt_wr_ack = 1'b0;
    cyc(4);
    chk("rst_no_resp", {busy, 32'(mon_ack[1] - base_a), 32'(mon_err[1] - base_b)},
        {1'b0, 32'd0, 32'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
